uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin, message-granular arbiter that shares the single `uart_tx` serializer between `N_REQ` byte producers (debug console, status reporter, loopback echo, etc.). It grants one requester at a time and holds the grant until that requester's message ends, a burst limit is hit, or the requester stalls too long. It then drives `uart_tx` through its `tx_valid`/`tx_ready` handshake, one byte at a time, independent of `baud_tick` timing.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_BURST`, 16: max bytes per grant before forced release (1..255).
- `STALL_TIMEOUT`, 1023: clk cycles a granted requester may leave `req_valid` low mid-message before release (1..65535).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester byte available.
- `req_data`  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `req_last`  in  N_REQ  byte is final of message.
- `req_ready`  out  N_REQ  one-hot; byte i accepted when `req_valid[i] && req_ready[i]`.
- `uart_valid`  out  1  to `uart_tx.tx_valid`.
- `uart_data`  out  8  to `uart_tx.tx_data`.
- `uart_ready`  in  1  from `uart_tx.tx_ready`.
- `gnt_valid`  out  1  a grant is held.
- `gnt_id`  out  3  current/last granted index.

## Operation
- States: IDLE, FETCH, SEND, DRAIN.
- IDLE: if any `req_valid`, pick the first set bit at or after `rr_ptr`, wrapping modulo N_REQ. Register `gnt_id`, set `gnt_valid=1`, clear `burst_cnt` and `stall_cnt`, then go to FETCH.
- FETCH: `req_ready[gnt_id]=1`.
  - If `req_valid[gnt_id]`: latch `uart_data`/`last_q`, clear `stall_cnt`, go to SEND.
  - Else: increment `stall_cnt`. At `STALL_TIMEOUT` go to release.
- SEND: `uart_valid=1`, with data held stable. When `uart_ready==0` is sampled (byte accepted by `uart_tx` on a baud tick), go to DRAIN. `uart_valid` drops on that edge.
- DRAIN: wait for `uart_ready==1`.
  - If `last_q`, or `burst_cnt==MAX_BURST-1`: release.
  - Else: increment `burst_cnt` and go to FETCH.
- Release: `rr_ptr <= (gnt_id+1) mod N_REQ`, `gnt_valid <= 0`, go to IDLE. `gnt_id` keeps its value.
- Requesters other than `gnt_id` never see `req_ready`, even while their `req_valid` is high.
- `req_ready` is combinational from registered state and `gnt_id` only; it has no combinational path from `req_valid`.
- `uart_valid` and `uart_data` are registered.

## Timing
- Reset (async, immediate) values:
  - State IDLE; `rr_ptr=0`; `gnt_id=0`; `gnt_valid=0`.
  - `req_ready=0`; `uart_valid=0`; `uart_data=0x00`.
  - All counters 0.
- Latency: `req_valid` high in cycle 0 with IDLE → `req_ready` high in cycle 1 → `uart_valid` high in cycle 2.
- `uart_valid` may stay high for many cycles; acceptance is defined only by `uart_ready` falling.
- After `uart_ready` rises, the next `req_ready` follows one cycle later, in FETCH.
- Simultaneous requests: at most one grant per IDLE visit. The pointer guarantees each active requester is served within N_REQ grants.
- `req_last` with `burst_cnt` at its limit: single release; the pointer advances once.
- `rr_ptr` wraps from N_REQ-1 to 0.
- `stall_cnt` saturates and never wraps.
- Reset mid-SEND: `uart_valid` falls immediately. A byte already inside `uart_tx` is abandoned by that block's own reset on the shared `rst_n`.

## Structure
- `uart_pkg`: `arb_state_t` enum (IDLE/FETCH/SEND/DRAIN, 2 bits), `UART_DATA_W=8`, `GNT_ID_W=3`. The shared `uart_tx` state enum also moves here.
- Sub-module `rr_pick`: combinational N_REQ-wide rotate / priority-encode / rotate-back. Inputs are the request vector and `rr_ptr`; outputs are `any` and `idx`.
- Top-level instantiation connects `uart_tx_arbiter` to `uart_tx` directly. Neither block contains the other.

## Test plan
- **Single byte:** req0 sends 0x55 with last=1, `uart_tx` model, baud_tick every 16 clk → `uart_valid` high at cycle 2; serial frame 0,10101010,1; `gnt_valid` falls after `uart_ready` rises; `rr_ptr=1`.
- **Message lock:** req1 sends "ABC" (last on 'C') while req2 requests throughout → line carries 0x41,0x42,0x43 before any req2 byte; req2 then granted.
- **Fairness:** all 4 requesters hold single-byte last messages continuously, pointer at 3 → grant order 3,0,1,2,3; no `req_ready` to a non-granted index.
- **Burst limit:** MAX_BURST=4, req0 sends a 10-byte message while req1 is pending → 4 bytes from req0, then req1's byte, then req0 resumes.
- **Stall:** STALL_TIMEOUT=8, req2 drops `req_valid` after byte 1 of 3 → release after 8 cycles in FETCH; req3 is granted next.
- **Reset mid-frame:** assert `rst_n=0` during DRAIN → all outputs at reset values within the same cycle; after release, a fresh req0 0xA5 transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit path: arbiter FSM states and the
// serializer state encoding used by uart_tx.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned GNT_ID_W    = 3;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StSend,
    StDrain
  } arb_state_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate the request vector so rr_ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick import uart_pkg::*; #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [GNT_ID_W-1:0] ptr,
  output logic                any,
  output logic [GNT_ID_W-1:0] idx
);

  logic [N_REQ-1:0]    rot;
  logic [GNT_ID_W-1:0] enc;
  logic [GNT_ID_W:0]   sum;

  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    enc = '0;
    // Descending scan leaves the lowest set bit in enc.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = GNT_ID_W'(i);
    end
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= (GNT_ID_W + 1)'(N_REQ)) sum = sum - (GNT_ID_W + 1)'(N_REQ);
    idx = sum[GNT_ID_W-1:0];
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx serializer between
// N_REQ byte producers; grant held until message end, burst limit or stall timeout.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         uart_valid,
  output logic [UART_DATA_W-1:0]       uart_data,
  input  logic                         uart_ready,
  output logic                         gnt_valid,
  output logic [GNT_ID_W-1:0]          gnt_id
);

  arb_state_t             state_q, state_d;
  logic [GNT_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GNT_ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic                   gnt_valid_q, gnt_valid_d;
  logic                   last_q, last_d;
  logic                   uart_valid_q, uart_valid_d;
  logic [UART_DATA_W-1:0] uart_data_q, uart_data_d;
  logic [7:0]             burst_cnt_q, burst_cnt_d;
  logic [15:0]            stall_cnt_q, stall_cnt_d;

  logic                   pick_any;
  logic [GNT_ID_W-1:0]    pick_idx;
  logic                   sel_valid, sel_last, release_gnt;
  logic [UART_DATA_W-1:0] sel_data;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // req_ready depends only on registered state, never on req_valid.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_id_q == GNT_ID_W'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[UART_DATA_W*i +: UART_DATA_W];
        req_ready[i] = (state_q == StFetch);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_id_d     = gnt_id_q;
    gnt_valid_d  = gnt_valid_q;
    last_d       = last_q;
    uart_valid_d = uart_valid_q;
    uart_data_d  = uart_data_q;
    burst_cnt_d  = burst_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    release_gnt  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_id_d    = pick_idx;
          gnt_valid_d = 1'b1;
          burst_cnt_d = '0;
          stall_cnt_d = '0;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        if (sel_valid) begin
          uart_data_d  = sel_data;
          last_d       = sel_last;
          stall_cnt_d  = '0;
          uart_valid_d = 1'b1;
          state_d      = StSend;
        end else begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 16'd1;
          if (stall_cnt_d >= 16'(STALL_TIMEOUT)) release_gnt = 1'b1;
        end
      end
      StSend: begin
        // uart_tx signals acceptance by dropping tx_ready.
        if (!uart_ready) begin
          uart_valid_d = 1'b0;
          state_d      = StDrain;
        end
      end
      StDrain: begin
        if (uart_ready) begin
          if (last_q || burst_cnt_q == 8'(MAX_BURST - 1)) begin
            release_gnt = 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
            state_d     = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (release_gnt) begin
      gnt_valid_d = 1'b0;
      state_d     = StIdle;
      rr_ptr_d    = (gnt_id_q == GNT_ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + GNT_ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      gnt_id_q     <= '0;
      gnt_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      uart_valid_q <= 1'b0;
      uart_data_q  <= '0;
      burst_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_id_q     <= gnt_id_d;
      gnt_valid_q  <= gnt_valid_d;
      last_q       <= last_d;
      uart_valid_q <= uart_valid_d;
      uart_data_q  <= uart_data_d;
      burst_cnt_q  <= burst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign uart_valid = uart_valid_q;
  assign uart_data  = uart_data_q;
  assign gnt_valid  = gnt_valid_q;
  assign gnt_id     = gnt_id_q;

endmodule
